// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style nibble receiver: mode encoding,
// command opcode masks, DDRAM geometry and address helpers.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_INIT8 = 2'd0,
        MODE_HI    = 2'd1,
        MODE_LO    = 2'd2
    } lcd_mode_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_SET_DDRAM
    } lcd_cmd_t;

    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_FUNC      = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISPLAY   = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    localparam logic [6:0] ROW0_BASE  = 7'h00;
    localparam logic [6:0] ROW1_BASE  = 7'h40;
    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam int         CLEAR_LEN  = 32;

    // Commands are classified by their highest set bit.
    function automatic lcd_cmd_t decode_cmd(input logic [7:0] b);
        lcd_cmd_t c;
        if      (|(b & OP_SET_DDRAM)) c = CMD_SET_DDRAM;
        else if (|(b & OP_FUNC))      c = CMD_FUNC;
        else if (|(b & OP_SHIFT))     c = CMD_SHIFT;
        else if (|(b & OP_DISPLAY))   c = CMD_DISPLAY;
        else if (|(b & OP_ENTRY))     c = CMD_ENTRY;
        else if (|(b & OP_HOME))      c = CMD_HOME;
        else if (|(b & OP_CLEAR))     c = CMD_CLEAR;
        else                          c = CMD_NOP;
        return c;
    endfunction

    function automatic logic addr_ok(input logic [6:0] a);
        return (a[6:4] == ROW0_BASE[6:4]) || (a[6:4] == ROW1_BASE[6:4]);
    endfunction

    function automatic logic [4:0] cell_of(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Rows are 16 cells each; stepping off the end of one row enters the other.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if      (a == ROW0_BASE + 7'h0F) n = ROW1_BASE;
            else if (a == ROW1_BASE + 7'h0F) n = ROW0_BASE;
            else                             n = a + 7'd1;
        end else begin
            if      (a == ROW0_BASE)         n = ROW1_BASE + 7'h0F;
            else if (a == ROW1_BASE)         n = ROW0_BASE + 7'h0F;
            else                             n = a - 7'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lcd_nibble_receiver_if.sv
// 4-bit LCD bus: the driver owns every signal, the receiver only observes.
// Write transfers: RS/W/data are stable while E is high and are taken on E's falling edge.
interface lcd_nibble_receiver_if;
    logic       LCD_RS;
    logic       LCD_E;
    logic       LCD_W;
    logic [3:0] data;

    modport master (output LCD_RS, output LCD_E, output LCD_W, output data);
    modport slave  (input  LCD_RS, input  LCD_E, input  LCD_W, input  data);
endinterface

// File: rtl/lcd_strobe_sync.sv
// Synchronizes the asynchronous LCD bus and flags the falling edge of E,
// presenting the RS/W/data values captured while E was still high.
module lcd_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e_in,
    input  logic       rs_in,
    input  logic       w_in,
    input  logic [3:0] data_in,
    output logic       strobe,
    output logic       rs,
    output logic       w,
    output logic [3:0] nib
);

    logic [6:0] raw;
    logic [6:0] synced;
    logic [6:0] prev_q;

    assign raw = {e_in, rs_in, w_in, data_in};

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign synced = raw;
        end else begin : g_sync
            logic [6:0] stage_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign synced = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= synced;
    end

    assign strobe = prev_q[6] & ~synced[6];
    assign rs     = prev_q[5];
    assign w      = prev_q[4];
    assign nib    = prev_q[3:0];

endmodule

// File: rtl/lcd_nibble_receiver.sv
// HD44780-style responder: assembles nibbles into bytes, executes commands and
// character writes, and exposes the 2x16 DDRAM image as two packed line vectors.
module lcd_nibble_receiver
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOME_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_nibble_receiver_if.slave bus,
    output logic [127:0]         line1,
    output logic [127:0]         line2,
    output logic                 display_on,
    output logic                 busy,
    output logic                 byte_valid,
    output logic [7:0]           byte_out,
    output logic                 byte_rs,
    output logic                 err,
    output lcd_mode_t            dbg_mode
);

    logic       strobe, s_rs, s_w;
    logic [3:0] s_nib;

    lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .e_in    (bus.LCD_E),
        .rs_in   (bus.LCD_RS),
        .w_in    (bus.LCD_W),
        .data_in (bus.data),
        .strobe  (strobe),
        .rs      (s_rs),
        .w       (s_w),
        .nib     (s_nib)
    );

    lcd_mode_t   mode_q, mode_d;
    logic [3:0]  upper_q, upper_d;
    logic        hi_rs_q, hi_rs_d;
    logic [6:0]  addr_q, addr_d;
    logic        id_q, id_d;
    logic        disp_q, disp_d;
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        clearing_q, clearing_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_rs_q, byte_rs_d;
    logic [7:0]  ddram_q [32];

    logic        wr_en, clr_en;
    logic [4:0]  wr_idx, clr_idx;
    logic [7:0]  wr_data, full_byte;
    lcd_cmd_t    cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_INIT8;
            upper_q    <= 4'h0;
            hi_rs_q    <= 1'b0;
            addr_q     <= ROW0_BASE;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            busy_cnt_q <= '0;
            clearing_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            byte_q     <= 8'h00;
            byte_rs_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            upper_q    <= upper_d;
            hi_rs_q    <= hi_rs_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            busy_cnt_q <= busy_cnt_d;
            clearing_q <= clearing_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            byte_q     <= byte_d;
            byte_rs_q  <= byte_rs_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        upper_d    = upper_q;
        hi_rs_d    = hi_rs_q;
        addr_d     = addr_q;
        id_d       = id_q;
        disp_d     = disp_q;
        busy_cnt_d = busy_cnt_q;
        clearing_d = clearing_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        byte_d     = byte_q;
        byte_rs_d  = byte_rs_q;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_data    = '0;
        clr_en     = 1'b0;
        clr_idx    = '0;
        full_byte  = {upper_q, s_nib};
        cmd        = decode_cmd(full_byte);

        if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 16'd1;
            if (clearing_q) begin
                clr_en  = 1'b1;
                clr_idx = 5'(16'(CLEAR_LEN) - busy_cnt_q);
            end
            if (busy_cnt_q == 16'd1) begin
                clearing_d = 1'b0;
                if (clearing_q) begin
                    addr_d = ROW0_BASE;
                    id_d   = 1'b1;
                end
            end
        end

        // A strobe landing on the final busy cycle sees the post-clear address and I/D.
        if (strobe) begin
            if (s_w || busy_cnt_q > 16'd1) begin
                err_d = 1'b1;
            end else begin
                unique case (mode_q)
                    MODE_INIT8: begin
                        if (s_nib == 4'h2)      mode_d = MODE_HI;
                        else if (s_nib != 4'h3) err_d  = 1'b1;
                    end
                    MODE_HI: begin
                        upper_d = s_nib;
                        hi_rs_d = s_rs;
                        mode_d  = MODE_LO;
                    end
                    MODE_LO: begin
                        mode_d = MODE_HI;
                        if (s_rs != hi_rs_q) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            byte_d    = full_byte;
                            byte_rs_d = s_rs;
                            if (s_rs) begin
                                wr_en   = 1'b1;
                                wr_idx  = cell_of(addr_d);
                                wr_data = full_byte;
                                addr_d  = step_addr(addr_d, id_d);
                            end else begin
                                unique case (cmd)
                                    CMD_SET_DDRAM: begin
                                        if (addr_ok(full_byte[6:0])) addr_d = full_byte[6:0];
                                        else                         err_d  = 1'b1;
                                    end
                                    CMD_FUNC:    if (full_byte[4]) mode_d = MODE_INIT8;
                                    CMD_DISPLAY: disp_d = full_byte[2];
                                    CMD_ENTRY:   id_d   = full_byte[1];
                                    CMD_HOME: begin
                                        addr_d     = ROW0_BASE;
                                        busy_cnt_d = 16'(HOME_CYCLES);
                                        clearing_d = 1'b0;
                                    end
                                    CMD_CLEAR: begin
                                        busy_cnt_d = 16'(CLEAR_LEN);
                                        clearing_d = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: mode_d = MODE_INIT8;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ddram_q[i] <= BLANK_CHAR;
        end else begin
            if (clr_en) ddram_q[clr_idx] <= BLANK_CHAR;
            if (wr_en)  ddram_q[wr_idx]  <= wr_data;
        end
    end

    generate
        for (genvar c = 0; c < 16; c++) begin : g_line
            assign line1[127-8*c -: 8] = ddram_q[c];
            assign line2[127-8*c -: 8] = ddram_q[16+c];
        end
    endgenerate

    assign display_on = disp_q;
    assign busy       = (busy_cnt_q != '0);
    assign byte_valid = valid_q;
    assign byte_out   = byte_q;
    assign byte_rs    = byte_rs_q;
    assign err        = err_q;
    assign dbg_mode   = mode_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Bench for lcd_nibble_receiver: nibble-level bus driver, completed-byte
// scoreboard, and per-feature scenario tasks.
module tb_lcd_nibble_receiver;
    import lcd_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [127:0] line1, line2;
    logic         display_on, busy, byte_valid, byte_rs, err;
    logic [7:0]   byte_out;
    lcd_mode_t    dbg_mode;

    lcd_nibble_receiver_if bus_if ();

    lcd_nibble_receiver #(.SYNC_STAGES(2), .HOME_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .line1      (line1),
        .line2      (line2),
        .display_on (display_on),
        .busy       (busy),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_rs    (byte_rs),
        .err        (err),
        .dbg_mode   (dbg_mode)
    );

    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         busy_run = 0;
    int         last_busy_len = 0;
    logic [8:0] exp_q [$];
    logic [8:0] exp_v;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard and pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid === 1'b1) begin
                valid_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got rs=%b byte=%h required none", byte_rs, byte_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({byte_rs, byte_out} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_byte got rs=%b byte=%h required rs=%b byte=%h",
                                 byte_rs, byte_out, exp_v[8], exp_v[7:0]);
                    end
                end
            end
            if (err === 1'b1) err_cnt++;
            if (busy === 1'b1) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
        end
    end

    // Driver tasks
    task automatic send_nibble(input logic rs, input logic w, input logic [3:0] n);
        @(negedge clk);
        bus_if.LCD_RS = rs;
        bus_if.LCD_W  = w;
        bus_if.data   = n;
        @(negedge clk);
        bus_if.LCD_E = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.LCD_E = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        send_nibble(rs, 1'b0, b[7:4]);
        send_nibble(rs, 1'b0, b[3:0]);
    endtask

    task automatic apply_reset();
        bus_if.LCD_RS = 1'b0;
        bus_if.LCD_E  = 1'b0;
        bus_if.LCD_W  = 1'b0;
        bus_if.data   = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_init();
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h2);
        send_byte(1'b0, 8'h28);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (line1 !== BLANK_LINE || line2 !== BLANK_LINE) begin
            errors++;
            $display("FAIL %s_lines got %h %h required all 20", tag, line1, line2);
        end
        checks++;
        if ({display_on, busy, byte_valid, byte_out, byte_rs, err} !== 13'h0) begin
            errors++;
            $display("FAIL %s_outputs got disp=%b busy=%b v=%b byte=%h rs=%b err=%b required all 0",
                     tag, display_on, busy, byte_valid, byte_out, byte_rs, err);
        end
        checks++;
        if (dbg_mode !== MODE_INIT8) begin
            errors++;
            $display("FAIL %s_mode got %0d required INIT8", tag, dbg_mode);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.LCD_RS = 1'b0;
        bus_if.LCD_E  = 1'b0;
        bus_if.LCD_W  = 1'b0;
        bus_if.data   = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_init();
        int v0;
        v0 = valid_cnt;
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h2);
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL init_no_valid got %0d required 0", valid_cnt - v0);
        end
        checks++;
        if (dbg_mode !== MODE_HI) begin
            errors++;
            $display("FAIL init_mode_hi got %0d required HI", dbg_mode);
        end
        send_byte(1'b0, 8'h28);
        checks++;
        if (byte_out !== 8'h28 || dbg_mode !== MODE_HI) begin
            errors++;
            $display("FAIL init_funcset got byte=%h mode=%0d required 28 HI", byte_out, dbg_mode);
        end
    endtask

    task automatic test_display_write();
        send_byte(1'b0, 8'h0C);
        send_byte(1'b1, 8'h41);
        send_byte(1'b1, 8'h42);
        checks++;
        if (display_on !== 1'b1) begin
            errors++;
            $display("FAIL disp_on got %b required 1", display_on);
        end
        checks++;
        if (line1 !== {8'h41, 8'h42, {14{8'h20}}} || line2 !== BLANK_LINE) begin
            errors++;
            $display("FAIL write_ab got %h %h required 4142+blank", line1, line2);
        end
    endtask

    task automatic test_wrap_inc();
        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h5A);
        send_byte(1'b1, 8'h5B);
        checks++;
        if (line1 !== {8'h41, 8'h42, {13{8'h20}}, 8'h5A} || line2 !== {8'h5B, {15{8'h20}}}) begin
            errors++;
            $display("FAIL wrap_inc got %h %h required col15=5A row1col0=5B", line1, line2);
        end
    endtask

    task automatic test_wrap_dec();
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h31);
        send_byte(1'b1, 8'h32);
        checks++;
        if (line2[127:120] !== 8'h31 || line1[7:0] !== 8'h32) begin
            errors++;
            $display("FAIL wrap_dec got l2c0=%h l1c15=%h required 31 32", line2[127:120], line1[7:0]);
        end
    endtask

    task automatic test_clear();
        int e0;
        int n;
        send_byte(1'b0, 8'h06);
        send_byte(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'h41);
        checks++;
        if (line1 !== {16{8'h41}}) begin
            errors++;
            $display("FAIL fill got %h required all 41", line1);
        end
        e0 = err_cnt;
        send_byte(1'b0, 8'h01);
        send_nibble(1'b1, 1'b0, 4'h7);
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL busy_strobe_err got %0d required 1", err_cnt - e0);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (n >= 100 || last_busy_len != 32) begin
            errors++;
            $display("FAIL clear_busy_len got %0d required 32 (waited %0d)", last_busy_len, n);
        end
        checks++;
        if (line1 !== BLANK_LINE || line2 !== BLANK_LINE || dbg_mode !== MODE_HI) begin
            errors++;
            $display("FAIL clear_image got %h %h mode=%0d required blank HI", line1, line2, dbg_mode);
        end
        send_byte(1'b1, 8'h5A);
        checks++;
        if (line1[127:120] !== 8'h5A) begin
            errors++;
            $display("FAIL clear_home got %h required 5A", line1[127:120]);
        end
    endtask

    task automatic test_errors();
        int e0;
        int v0;
        e0 = err_cnt;
        send_byte(1'b0, 8'h90);
        send_byte(1'b1, 8'h44);
        checks++;
        if (err_cnt - e0 != 1 || line1[119:112] !== 8'h44) begin
            errors++;
            $display("FAIL bad_addr got errs=%0d col1=%h required 1 44", err_cnt - e0, line1[119:112]);
        end
        e0 = err_cnt;
        v0 = valid_cnt;
        send_nibble(1'b0, 1'b0, 4'h4);
        send_nibble(1'b1, 1'b0, 4'h1);
        checks++;
        if (err_cnt - e0 != 1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL rs_change got errs=%0d valids=%0d required 1 0", err_cnt - e0, valid_cnt - v0);
        end
        send_byte(1'b1, 8'h45);
        e0 = err_cnt;
        send_nibble(1'b0, 1'b1, 4'hF);
        send_byte(1'b1, 8'h46);
        checks++;
        if (err_cnt - e0 != 1 || line1[111:96] !== 16'h4546) begin
            errors++;
            $display("FAIL read_strobe got errs=%0d cols=%h required 1 4546", err_cnt - e0, line1[111:96]);
        end
    endtask

    task automatic test_random_line();
        logic [127:0] exp_l2;
        logic [7:0]   b;
        send_byte(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(8'h21, 8'h7E));
            exp_l2[127-8*i -: 8] = b;
            send_byte(1'b1, b);
        end
        checks++;
        if (line2 !== exp_l2) begin
            errors++;
            $display("FAIL random_line2 got %h required %h", line2, exp_l2);
        end
        checks++;
        if (line1 !== {8'h5A, 8'h44, 8'h45, 8'h46, {12{8'h20}}}) begin
            errors++;
            $display("FAIL random_line1 got %h required 5A444546+blank", line1);
        end
    endtask

    task automatic test_reset_mid();
        send_nibble(1'b1, 1'b0, 4'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid_byte");
        apply_reset();
        do_init();
        send_byte(1'b1, 8'h55);
        send_byte(1'b0, 8'h01);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid_clear");
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_init();
        test_display_write();
        test_wrap_inc();
        test_wrap_dec();
        test_clear();
        test_errors();
        test_random_line();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_receiver.md
Name: lcd_nibble_receiver

Overview:
- Synthesizable HD44780-style responder for the 4-bit LCD bus (RS, E, W, data[3:0]) produced by the team's LCD driver.
- Decodes strobes into commands and character writes and keeps a 2x16 DDRAM image.
- Presents the image as two 128-bit line vectors, in the same packing the driver consumes, so driver output can be checked end-to-end in simulation or on a loopback board.

Parameters:
- SYNC_STAGES, 2, input synchronizer depth on all bus inputs; 0 = sample directly.
- HOME_CYCLES, 16, busy duration in clk cycles after Return Home.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- LCD_RS  input  1  register select: 0 = command, 1 = data
- LCD_E  input  1  enable strobe; latched on falling edge
- LCD_W  input  1  1 = read, 0 = write
- data  input  4  nibble bus
- line1  output  128  row 0; column 0 in [127:120], column 15 in [7:0]
- line2  output  128  row 1, same packing
- display_on  output  1  D bit from Display Control
- busy  output  1  high while Clear or Home executes
- byte_valid  output  1  one-cycle pulse per completed byte
- byte_out  output  8  last completed byte; held until the next byte
- byte_rs  output  1  RS of last completed byte
- err  output  1  one-cycle pulse on protocol error

Behaviour:
- Async reset:
  - All 32 DDRAM cells = 8'h20.
  - Address = 7'h00, I/D = 1, display_on = 0, busy = 0, byte_out = 0, byte_rs = 0, pulses low.
  - Mode = INIT8.
- Strobe detection:
  - Strobe = synchronized E high in the previous cycle and low in the current cycle.
  - RS, W and data are taken from the previous-cycle (E-high) sample.
  - Every action below occurs in the cycle after strobe detection.
- W = 1 strobes: ignored entirely (nibble phase unchanged); err pulses.
- Mode states:
  - INIT8: each strobe is a full byte {data, 4'h0}.
    - 0x3 nibble: stay INIT8, no byte_valid.
    - 0x2 nibble: go to HI, no byte_valid.
    - Any other nibble: err, stay INIT8.
  - HI: latch upper nibble, go to LO.
  - LO: byte = {upper, data}; go to HI; byte_valid = 1; execute the byte.
  - RS change between HI and LO: err; discard the byte; go to HI.
- Command decode (RS = 0), by highest set bit:
  - 1xxxxxxx, Set DDRAM address:
    - Accept a in 0x00–0x0F or 0x40–0x4F.
    - Any other a: err, address unchanged.
  - 001xxxxx, Function Set:
    - DL = 1 returns the block to INIT8.
    - DL = 0: no state change.
  - 0001xxxx, cursor/shift: no-op.
  - 00001DCB: display_on = D.
  - 000001IS: I/D = I; S ignored.
  - 0000001x, Home: address = 0; busy for HOME_CYCLES.
  - 00000001, Clear:
    - Busy for exactly 32 cycles.
    - Writes 8'h20 to one cell per cycle, cell 0 through 31.
    - Address = 0, I/D = 1 at completion.
  - 00000000: no-op.
- Data write (RS = 1):
  - DDRAM[address] = byte.
  - Address then steps by I/D with wrap: 0x0F→0x40, 0x4F→0x00 (increment); 0x00→0x4F, 0x40→0x0F (decrement).
- Busy rules:
  - Strobes while busy: err; nibble ignored; phase unchanged.
  - A strobe in the same cycle busy falls is accepted.
- Simultaneous byte completion and reset: reset wins.
- Reset mid-clear: DDRAM returns to all 8'h20 immediately.

Decomposition:
- Package lcd_pkg holds:
  - Mode encoding (INIT8, HI, LO).
  - Command opcode masks.
  - Row base addresses 7'h00 and 7'h40.
  - Blank char 8'h20.
  - Clear length 32.
- One natural sub-module, lcd_strobe_sync:
  - Input synchronizer and E falling-edge detector.
  - Outputs strobe, rs, w, nib.
- Core FSM, address counter and DDRAM stay in the top.

Test Plan:
- Reset, then E strobes with data 3,3,3,2 → no byte_valid; next nibbles 2,8 (RS = 0) → byte_valid, byte_out = 8'h28, mode HI.
- After init, command 8'h0C, then RS = 1 bytes 8'h41, 8'h42 → display_on = 1, line1[127:112] = 16'h4142, rest 8'h20.
- Command 8'h8F, then data 8'h5A, 8'h5B → line1[7:0] = 8'h5A, line2[127:120] = 8'h5B (wrap 0x0F→0x40).
- Command 8'h04, then Set address 8'hC0, then data 8'h31, 8'h32 → line2[127:120] = 8'h31, line1[7:0] = 8'h32 (wrap 0x40→0x0F).
- Fill line1 with 8'h41, then command 8'h01 → busy high exactly 32 cycles; a strobe mid-clear gives err = 1; afterwards line1 = {16{8'h20}}, next data lands at column 0.
- Set address 8'h90 → err, address unchanged. HI nibble with RS = 0 then LO nibble with RS = 1 → err, no byte_valid. Assert rst_n low mid-byte → all outputs at reset values.
